// File: rtl/stream_demux_pkg.sv
// Shared constants, select type and select-range helper for the stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned CNT_W  = 16;

  typedef logic [3:0] ch_sel_t;

  // True when the select addresses an existing channel.
  function automatic logic sel_valid(input ch_sel_t sel, input int unsigned n_ch);
    return (32'(sel) < n_ch);
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer/consumer bundle of the stream demultiplexer; slave is the demux view, master the environment view.
interface stream_demux_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8
);
  localparam int unsigned SW = $clog2(N_CH);

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic [N_CH-1:0] out_valid;
  logic [N_CH-1:0] out_ready;
  logic [DW-1:0]   out_data;
  logic            drop;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop
  );
endinterface

// File: rtl/stream_demux_stage.sv
// Single holding register (full/data_q/sel_q) with the ready equation of the demux.
module stream_demux_stage #(
  parameter int unsigned DW = 8,
  parameter int unsigned SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [SW-1:0] in_sel,
  input  logic          load_ok,
  input  logic          ready_sel,
  output logic          in_ready,
  output logic          accept,
  output logic          full,
  output logic [DW-1:0] data_q,
  output logic [SW-1:0] sel_q
);
  logic deliver;

  assign in_ready = !full || ready_sel;
  assign accept   = in_valid && in_ready;
  assign deliver  = full && ready_sel;

  // A discarded beat never loads, so the deliver rule alone decides full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
    end else if (accept && load_ok) begin
      full   <= 1'b1;
      data_q <= in_data;
      sel_q  <= in_sel;
    end else if (deliver) begin
      full   <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux.sv
// 1-to-N stream demultiplexer with one registered stage and out-of-range drop pulse.
// Optional per-channel delivery counters: define STREAM_DEMUX_CNT_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_demux_if.slave         bus
`ifdef STREAM_DEMUX_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [N_CH*CNT_W-1:0] beat_cnt
`endif
);
  localparam int unsigned SW = $clog2(N_CH);

  logic            full;
  logic [DW-1:0]   data_q;
  logic [SW-1:0]   sel_q;
  logic            accept;
  logic            load_ok;
  logic            ready_sel;
  logic            drop_q;
  logic [N_CH-1:0] sel_hit;
  ch_sel_t         sel_ext;

  always_comb begin
    sel_ext             = '0;
    sel_ext[SW-1:0]     = bus.in_sel;
    load_ok             = sel_valid(sel_ext, N_CH);
  end

  // Decoding sel_q against real channels keeps in_ready free of out-of-range indexing.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sel_hit[k] = (sel_q == SW'(k));
    end
  end

  assign ready_sel     = |(sel_hit & bus.out_ready);
  assign bus.out_valid = full ? sel_hit : '0;
  assign bus.out_data  = data_q;
  assign bus.drop      = drop_q;

  stream_demux_stage #(
    .DW (DW),
    .SW (SW)
  ) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_data   (bus.in_data),
    .in_sel    (bus.in_sel),
    .load_ok   (load_ok),
    .ready_sel (ready_sel),
    .in_ready  (bus.in_ready),
    .accept    (accept),
    .full      (full),
    .data_q    (data_q),
    .sel_q     (sel_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= accept && !load_ok;
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else if (cnt_clr) begin
      for (int unsigned k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int unsigned k = 0; k < N_CH; k++) beat_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 4-channel and a 3-channel instance against a queue model.
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.N_CH(4), .DW(8)) bus4 ();
  stream_demux_if #(.N_CH(3), .DW(8)) bus3 ();

`ifdef STREAM_DEMUX_CNT_EN
  logic        cnt_clr4 = 1'b0;
  logic        cnt_clr3 = 1'b0;
  logic [63:0] beat_cnt4;
  logic [47:0] beat_cnt3;
  logic [15:0] cnt_m [4];
`endif

  stream_demux #(.N_CH(4), .DW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt_clr(cnt_clr4), .beat_cnt(beat_cnt4)
`endif
  );

  stream_demux #(.N_CH(3), .DW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt_clr(cnt_clr3), .beat_cnt(beat_cnt3)
`endif
  );

  typedef struct {
    logic [7:0]  d;
    int unsigned ch;
  } beat_t;

  beat_t       sbq [2][$];
  logic        drop_exp  [2];
  logic        stall_prev[2];
  logic [7:0]  dat_prev  [2];
  logic [1:0]  sel_prev  [2];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        rand_run;

  task automatic check(input int unsigned id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got 0x%0h required 0x%0h at %0t", id, nm, act, exp, $time);
    end
  endtask

  // One model step per cycle, evaluated mid-cycle: compare, then advance past the coming edge.
  task automatic sb_step(input int unsigned id, input int unsigned n, input logic [3:0] ov,
                         input logic [3:0] ordy, input logic [7:0] od, input logic ir,
                         input logic iv, input logic [7:0] idat, input logic [1:0] isel,
                         input logic dr);
    logic [3:0] exp_ov;
    logic       exp_ir;
    logic       dlv;
    exp_ov = '0;
    dlv    = 1'b0;
    if (sbq[id].size() != 0) begin
      exp_ov[sbq[id][0].ch] = 1'b1;
      dlv = ordy[sbq[id][0].ch];
    end
    exp_ir = (sbq[id].size() == 0) || dlv;
    check(id, "out_valid", 32'(ov), 32'(exp_ov));
    if (sbq[id].size() != 0) check(id, "out_data", 32'(od), 32'(sbq[id][0].d));
    check(id, "in_ready", 32'(ir), 32'(exp_ir));
    check(id, "drop", 32'(dr), 32'(drop_exp[id]));
    if (stall_prev[id] && iv)
      assert (idat == dat_prev[id] && isel == sel_prev[id]) else $error("producer changed a stalled beat");
    stall_prev[id] = iv && !ir;
    dat_prev[id]   = idat;
    sel_prev[id]   = isel;
`ifdef STREAM_DEMUX_CNT_EN
    if (id == 0) begin
      for (int k = 0; k < 4; k++) begin
        check(id, "beat_cnt", 32'(beat_cnt4[k*16 +: 16]), 32'(cnt_m[k]));
        if (cnt_clr4) cnt_m[k] = 16'd0;
        else if (dlv && sbq[0][0].ch == k) cnt_m[k] = cnt_m[k] + 16'd1;
      end
    end
`endif
    if (dlv) void'(sbq[id].pop_front());
    drop_exp[id] = 1'b0;
    if (iv && exp_ir) begin
      if (32'(isel) < n) sbq[id].push_back('{d: idat, ch: 32'(isel)});
      else drop_exp[id] = 1'b1;
    end
  endtask

  task automatic model_reset(input int unsigned id);
    sbq[id].delete();
    drop_exp[id]   = 1'b0;
    stall_prev[id] = 1'b0;
`ifdef STREAM_DEMUX_CNT_EN
    if (id == 0) for (int k = 0; k < 4; k++) cnt_m[k] = 16'd0;
`endif
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset(0);
    else sb_step(0, 4, bus4.out_valid, bus4.out_ready, bus4.out_data, bus4.in_ready,
                 bus4.in_valid, bus4.in_data, bus4.in_sel, bus4.drop);
  end

  always @(negedge clk) begin
    if (!rst_n) model_reset(1);
    else sb_step(1, 3, {1'b0, bus3.out_valid}, {1'b0, bus3.out_ready}, bus3.out_data, bus3.in_ready,
                 bus3.in_valid, bus3.in_data, bus3.in_sel, bus3.drop);
  end

  // Present one beat at posedge+1, hold it until accepted; returns at posedge+1 after acceptance.
  task automatic send(input int unsigned id, input logic [7:0] d, input logic [1:0] s);
    int unsigned t;
    logic        rdy;
    t = 0;
    if (id == 0) begin bus4.in_valid = 1'b1; bus4.in_data = d; bus4.in_sel = s; end
    else         begin bus3.in_valid = 1'b1; bus3.in_data = d; bus3.in_sel = s; end
    do begin
      @(negedge clk);
      t++;
      rdy = (id == 0) ? bus4.in_ready : bus3.in_ready;
    end while (!rdy && t < 40);
    n_chk++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL dut%0d accept_timeout: got no in_ready in %0d cycles required acceptance", id, t);
    end
    @(posedge clk);
    #1;
    if (id == 0) bus4.in_valid = 1'b0;
    else         bus3.in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int unsigned id, input int unsigned nbeats);
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < int'(nbeats); i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(id, 8'($urandom), 2'($urandom_range(0, 3)));
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          @(posedge clk);
          #1;
          bus4.out_ready = 4'($urandom);
          bus3.out_ready = 3'($urandom);
        end
      end
    join
    bus4.out_ready = 4'hF;
    bus3.out_ready = 3'h7;
    idle(3);
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_sel = '0; bus4.out_ready = '0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.in_sel = '0; bus3.out_ready = '0;
    for (int i = 0; i < 2; i++) model_reset(i);
    idle(2);
    check(0, "rst_out_valid", 32'(bus4.out_valid), 32'h0);
    check(0, "rst_out_data",  32'(bus4.out_data),  32'h0);
    check(0, "rst_in_ready",  32'(bus4.in_ready),  32'h1);
    check(1, "rst_drop",      32'(bus3.drop),      32'h0);
    rst_n = 1'b1;
    idle(1);

    // Routing, back-to-back with all consumers ready.
    bus4.out_ready = 4'hF;
    send(0, 8'h11, 2'd0);
    send(0, 8'h22, 2'd1);
    send(0, 8'h33, 2'd2);
    send(0, 8'h44, 2'd3);
    idle(2);

    // Backpressure on ch1, queued beat accepted on release.
    bus4.out_ready = 4'b1101;
    send(0, 8'h5A, 2'd1);
    fork
      send(0, 8'h6B, 2'd0);
      begin idle(3); bus4.out_ready = 4'hF; end
    join
    idle(2);

    // Ready on other channels must not release a beat held for ch3.
    bus4.out_ready = 4'b0111;
    send(0, 8'hA0, 2'd3);
    fork
      send(0, 8'hB0, 2'd0);
      begin idle(3); bus4.out_ready = 4'hF; end
    join
    idle(2);

    // Out-of-range select on the 3-channel instance.
    bus3.out_ready = 3'h7;
    send(1, 8'h01, 2'd0);
    send(1, 8'h02, 2'd3);
    send(1, 8'h03, 2'd2);
    send(1, 8'h04, 2'd3);
    idle(3);
    bus3.out_ready = 3'b000;
    send(1, 8'h05, 2'd1);
    idle(2);
    bus3.out_ready = 3'h7;
    idle(2);

    random_phase(0, 200);
    random_phase(1, 200);

    // Asynchronous reset while a beat is held.
    bus4.out_ready = 4'h0;
    send(0, 8'hA5, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check(0, "async_rst_out_valid", 32'(bus4.out_valid), 32'h0);
    check(0, "async_rst_out_data",  32'(bus4.out_data),  32'h0);
    idle(2);
    rst_n = 1'b1;
    bus4.out_ready = 4'hF;
    idle(4);

`ifdef STREAM_DEMUX_CNT_EN
    do_reset();
    bus4.out_ready = 4'hF;
    repeat (5) send(0, 8'($urandom), 2'd0);
    repeat (2) send(0, 8'($urandom), 2'd2);
    idle(2);
    check(0, "cnt_ch0", 32'(beat_cnt4[15:0]),  32'd5);
    check(0, "cnt_ch2", 32'(beat_cnt4[47:32]), 32'd2);
    check(0, "cnt_ch1", 32'(beat_cnt4[31:16]), 32'd0);
    send(0, 8'h77, 2'd0);
    cnt_clr4 = 1'b1;
    idle(1);
    cnt_clr4 = 1'b0;
    idle(1);
    check(0, "cnt_clr_ch0", 32'(beat_cnt4[15:0]),  32'd0);
    check(0, "cnt_clr_ch2", 32'(beat_cnt4[47:32]), 32'd0);
`else
    do_reset();
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion before 400000");
    $fatal(1, "watchdog expired");
  end
endmodule
